// File: rtl/add_serial_pkg.sv
// add_serial_pkg: state encodings and width helper shared by the serial adder.
package add_serial_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  function automatic int clog2(input int v);
    int w;
    w = 0;
    while ((1 << w) < v) w++;
    return w;
  endfunction
endpackage

// File: rtl/add_1bit.sv
// add_1bit: single full-adder cell.
module add_1bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/add_serial_nbit.sv
// add_serial_nbit: bit-serial n-bit adder, one bit per clock via add_1bit.
// Defining ADD_SERIAL_SUB_MODE_EN adds a ctrl port selecting x - y - ci.
module add_serial_nbit
  import add_serial_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  input  logic         ci,
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
`ifdef ADD_SERIAL_SUB_MODE_EN
  input  logic         ctrl,
`endif
  output logic [n-1:0] r,
  output logic         co
);
  localparam int cw = clog2(n);
  state_t state_q, state_d;
  logic [n-1:0] xs_q, xs_d, ys_q, ys_d, rs_q, rs_d, r_q, r_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic c_q, c_d, co_q, co_d, busy_q, busy_d, done_q, done_d;
  logic s, cout, sub, last;
`ifdef ADD_SERIAL_SUB_MODE_EN
  assign sub = ctrl;
`else
  assign sub = 1'b0;
`endif
  add_1bit u_fa (.a(xs_q[0]), .b(ys_q[0]), .ci(c_q), .s(s), .co(cout));
  assign last = cnt_q == cw'(n - 1);
  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    rs_d    = rs_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    co_d    = co_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q == ST_RUN) begin
      c_d   = cout;
      rs_d  = {s, rs_q[n-1:1]};
      xs_d  = xs_q >> 1;
      ys_d  = ys_q >> 1;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        r_d     = {s, rs_q[n-1:1]};
        co_d    = cout;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end
    end else if (start) begin
      xs_d    = x;
      ys_d    = y ^ {n{sub}};
      c_d     = ci ^ sub;
      cnt_d   = '0;
      busy_d  = 1'b1;
      state_d = ST_RUN;
    end else begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      rs_q    <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      rs_q    <= rs_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign r    = r_q;
  assign co   = co_q;
endmodule
